// File: rtl/reg_scoreboard_if.sv
// Bundle of the ID-stage scoreboard signals: issue, write-back, operand query
// and status. The pipeline side drives through "master"; the scoreboard
// receives through "slave".
interface reg_scoreboard_if #(
  parameter int REG_COUNT = 16,
  parameter int ID_W      = 4
);

  // Issue port: a register-writing instruction leaves ID
  logic                 issueEn;
  logic [ID_W-1:0]      issueDest;
  logic                 issueMemRead;

  // Write-back port: WB commits a register write
  logic                 wbEn;
  logic [ID_W-1:0]      wbDest;

  // Pipeline control
  logic                 freeze;
  logic                 forwardEn;

  // Operand query from the instruction sitting in ID
  logic [ID_W-1:0]      src1;
  logic [ID_W-1:0]      src2;
  logic                 twoSrc;

  // Status back to the pipeline
  logic                 hazard;
  logic [REG_COUNT-1:0] pending;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output issueEn, issueDest, issueMemRead,
    output wbEn, wbDest,
    output freeze, forwardEn,
    output src1, src2, twoSrc,
    input  hazard, pending, overflow, underflow
  );

  modport slave (
    input  issueEn, issueDest, issueMemRead,
    input  wbEn, wbDest,
    input  freeze, forwardEn,
    input  src1, src2, twoSrc,
    output hazard, pending, overflow, underflow
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard for the ID stage. Keeps a small saturating count of
// in-flight writes per architectural register plus a one-entry tracker of the
// load currently in EX, and from these raises the ID/IF stall. With
// forwarding only a load-use pair stalls; without it any uncommitted write to
// a source register stalls, except a write committing this very cycle, which
// the register file bypasses.
module reg_scoreboard #(
  parameter int REG_COUNT = 16,
  parameter int ID_W      = 4,
  parameter int CNT_W     = 2
) (
  input logic             clk,
  input logic             rst,
  reg_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Per-register pending-write counters
  logic [CNT_W-1:0] cnt_q [REG_COUNT];
  logic [CNT_W-1:0] cnt_d [REG_COUNT];

  // Sticky error flags
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  // One-entry tracker for the load in EX
  logic            ld_valid_q, ld_valid_d;
  logic [ID_W-1:0] ld_dest_q,  ld_dest_d;

  // Per-register decodes
  logic [REG_COUNT-1:0] inc_vec;
  logic [REG_COUNT-1:0] dec_vec;
  logic [REG_COUNT-1:0] src1_sel;
  logic [REG_COUNT-1:0] src2_sel;
  logic [REG_COUNT-1:0] eff_pend;
  logic [REG_COUNT-1:0] pending_vec;

  logic src1_pend;
  logic src2_pend;
  logic ld_hit;
  logic hazard;

  // Decode issue, write-back and operand register ids into one-hot vectors
  always_comb begin
    // NOTE: every signal written here gets a value before any condition, so no
    // path through the block leaves it unassigned and no latch is inferred.
    inc_vec  = '0;
    dec_vec  = '0;
    src1_sel = '0;
    src2_sel = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      inc_vec[i]  = sb.issueEn && (sb.issueDest == ID_W'(i));
      dec_vec[i]  = sb.wbEn    && (sb.wbDest    == ID_W'(i));
      src1_sel[i] = (sb.src1 == ID_W'(i));
      src2_sel[i] = (sb.src2 == ID_W'(i));
    end
  end

  // Counter next state: saturate on overflow, hold at zero on underflow
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    for (int i = 0; i < REG_COUNT; i++) begin
      cnt_d[i] = cnt_q[i];
      unique case ({inc_vec[i], dec_vec[i]})
        2'b10: begin
          if (cnt_q[i] == CNT_MAX) overflow_d = 1'b1;
          else                     cnt_d[i]   = cnt_q[i] + CNT_ONE;
        end
        2'b01: begin
          if (cnt_q[i] == CNT_ZERO) underflow_d = 1'b1;
          else                      cnt_d[i]    = cnt_q[i] - CNT_ONE;
        end
        // Issue and retire to the same register cancel out
        default: ;
      endcase
    end
  end

  // Load tracker next state: follows the issue port unless the pipe is frozen
  always_comb begin
    ld_valid_d = ld_valid_q;
    ld_dest_d  = ld_dest_q;
    if (!sb.freeze) begin
      ld_valid_d = sb.issueEn && sb.issueMemRead;
      ld_dest_d  = sb.issueDest;
    end
  end

  // Effective pending: a last write committing this cycle is already visible
  always_comb begin
    eff_pend    = '0;
    pending_vec = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      pending_vec[i] = (cnt_q[i] != CNT_ZERO);
      eff_pend[i]    = pending_vec[i] && !(dec_vec[i] && (cnt_q[i] == CNT_ONE));
    end
  end

  // Stall decision for the instruction in ID, zero latency
  always_comb begin
    src1_pend = |(eff_pend & src1_sel);
    src2_pend = |(eff_pend & src2_sel);
    ld_hit    = ld_valid_q &&
                ((ld_dest_q == sb.src1) || (sb.twoSrc && (ld_dest_q == sb.src2)));
    if (sb.forwardEn) hazard = ld_hit;
    else              hazard = src1_pend || (sb.twoSrc && src2_pend);
  end

  // State registers; reset clears everything at once, independent of clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the counter array is reset like any other flop because it holds
      // live pipeline state; a data RAM would normally be left unreset.
      for (int i = 0; i < REG_COUNT; i++) cnt_q[i] <= CNT_ZERO;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      ld_valid_q  <= 1'b0;
      ld_dest_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample its _d value
      // from before the edge, whatever order the statements appear in.
      for (int i = 0; i < REG_COUNT; i++) cnt_q[i] <= cnt_d[i];
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      ld_valid_q  <= ld_valid_d;
      ld_dest_q   <= ld_dest_d;
    end
  end

  assign sb.hazard    = hazard;
  assign sb.pending   = pending_vec;
  assign sb.overflow  = overflow_q;
  assign sb.underflow = underflow_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: plain hazard/retire, load-use with
// forwarding, freeze hold, same-cycle issue+retire, saturation, underflow
// and asynchronous reset in mid-cycle.
module tb_reg_scoreboard;

  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  reg_scoreboard_if #(.REG_COUNT(16), .ID_W(4)) sb_if ();

  reg_scoreboard #(.REG_COUNT(16), .ID_W(4), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sb_if.issueEn      = 1'b0;
    sb_if.issueDest    = 4'd0;
    sb_if.issueMemRead = 1'b0;
    sb_if.wbEn         = 1'b0;
    sb_if.wbDest       = 4'd0;
    sb_if.freeze       = 1'b0;
    sb_if.src1         = 4'd0;
    sb_if.src2         = 4'd0;
    sb_if.twoSrc       = 1'b0;
  endtask

  // One-cycle write-back of a register
  task automatic retire(input logic [3:0] r);
    sb_if.wbEn   = 1'b1;
    sb_if.wbDest = r;
    tick();
    sb_if.wbEn   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    sb_if.forwardEn = 1'b0;
    #1;
    check("rst_pending",   32'(sb_if.pending),   32'h0);
    check("rst_overflow",  32'(sb_if.overflow),  32'h0);
    check("rst_underflow", 32'(sb_if.underflow), 32'h0);
    check("rst_hazard",    32'(sb_if.hazard),    32'h0);
    #20;
    rst = 1'b0;
    tick();

    // No forwarding: issue r3, then read it
    sb_if.issueEn   = 1'b1;
    sb_if.issueDest = 4'd3;
    tick();
    sb_if.issueEn = 1'b0;
    sb_if.src1    = 4'd3;
    #1;
    check("nofwd_hazard_r3",  32'(sb_if.hazard),  32'h1);
    check("nofwd_pending_r3", 32'(sb_if.pending), 32'h0008);
    sb_if.wbEn   = 1'b1;
    sb_if.wbDest = 4'd3;
    #1;
    check("wb_bypass_hazard", 32'(sb_if.hazard), 32'h0);
    tick();
    sb_if.wbEn = 1'b0;
    #1;
    check("wb_pending_clear", 32'(sb_if.pending), 32'h0);
    check("wb_hazard_clear",  32'(sb_if.hazard),  32'h0);

    // No forwarding: src2 only counts when twoSrc is set
    sb_if.issueEn   = 1'b1;
    sb_if.issueDest = 4'd6;
    tick();
    sb_if.issueEn = 1'b0;
    sb_if.src1    = 4'd0;
    sb_if.src2    = 4'd6;
    sb_if.twoSrc  = 1'b0;
    #1;
    check("nofwd_src2_ignored", 32'(sb_if.hazard), 32'h0);
    sb_if.twoSrc = 1'b1;
    #1;
    check("nofwd_src2_used", 32'(sb_if.hazard), 32'h1);
    retire(4'd6);
    check("r6_retired", 32'(sb_if.pending), 32'h0);

    // Forwarding: load-use on src2
    clear_inputs();
    sb_if.forwardEn    = 1'b1;
    sb_if.issueEn      = 1'b1;
    sb_if.issueDest    = 4'd5;
    sb_if.issueMemRead = 1'b1;
    tick();
    sb_if.issueEn      = 1'b0;
    sb_if.issueMemRead = 1'b0;
    sb_if.issueDest    = 4'd0;
    sb_if.src1         = 4'd0;
    sb_if.src2         = 4'd5;
    sb_if.twoSrc       = 1'b1;
    #1;
    check("ldu_src2_hazard",  32'(sb_if.hazard),  32'h1);
    check("ldu_pending_r5",   32'(sb_if.pending), 32'h0020);
    sb_if.twoSrc = 1'b0;
    #1;
    check("ldu_src2_ignored", 32'(sb_if.hazard), 32'h0);
    tick();
    sb_if.twoSrc = 1'b1;
    #1;
    check("ldu_next_cycle", 32'(sb_if.hazard), 32'h0);

    // Forwarding: a non-load producer never stalls
    sb_if.src2 = 4'd0;
    sb_if.issueEn   = 1'b1;
    sb_if.issueDest = 4'd8;
    tick();
    sb_if.issueEn = 1'b0;
    sb_if.src1    = 4'd8;
    #1;
    check("fwd_alu_no_stall", 32'(sb_if.hazard), 32'h0);

    // Freeze holds the load tracker
    sb_if.issueEn      = 1'b1;
    sb_if.issueDest    = 4'd7;
    sb_if.issueMemRead = 1'b1;
    sb_if.src1         = 4'd0;
    sb_if.twoSrc       = 1'b0;
    tick();
    sb_if.issueEn      = 1'b0;
    sb_if.issueMemRead = 1'b0;
    sb_if.issueDest    = 4'd0;
    sb_if.freeze       = 1'b1;
    sb_if.src1         = 4'd7;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("freeze_hold_%0d", c), 32'(sb_if.hazard), 32'h1);
      tick();
    end
    sb_if.freeze = 1'b0;
    tick();
    check("freeze_release", 32'(sb_if.hazard), 32'h0);
    retire(4'd5);
    retire(4'd7);
    retire(4'd8);
    check("all_retired", 32'(sb_if.pending), 32'h0);

    // Same-cycle issue and retire on r2 with count 1
    clear_inputs();
    sb_if.forwardEn = 1'b0;
    sb_if.issueEn   = 1'b1;
    sb_if.issueDest = 4'd2;
    tick();
    sb_if.wbEn   = 1'b1;
    sb_if.wbDest = 4'd2;
    tick();
    sb_if.issueEn = 1'b0;
    sb_if.wbEn    = 1'b0;
    sb_if.src1    = 4'd2;
    #1;
    check("same_cycle_pending",   32'(sb_if.pending),   32'h0004);
    check("same_cycle_overflow",  32'(sb_if.overflow),  32'h0);
    check("same_cycle_underflow", 32'(sb_if.underflow), 32'h0);
    check("same_cycle_hazard",    32'(sb_if.hazard),    32'h1);
    retire(4'd2);
    check("r2_retired", 32'(sb_if.pending), 32'h0);

    // Saturation on r9
    sb_if.src1      = 4'd0;
    sb_if.issueEn   = 1'b1;
    sb_if.issueDest = 4'd9;
    tick();
    tick();
    tick();
    check("sat3_pending",  32'(sb_if.pending),  32'h0200);
    check("sat3_overflow", 32'(sb_if.overflow), 32'h0);
    tick();
    sb_if.issueEn = 1'b0;
    check("sat4_overflow", 32'(sb_if.overflow), 32'h1);
    check("sat4_pending",  32'(sb_if.pending),  32'h0200);
    // Count must be exactly 3: two retires leave it pending, the third clears
    retire(4'd9);
    retire(4'd9);
    check("sat_after2_pending", 32'(sb_if.pending), 32'h0200);
    retire(4'd9);
    check("sat_after3_pending", 32'(sb_if.pending), 32'h0);
    check("sat_no_underflow",   32'(sb_if.underflow), 32'h0);

    // Underflow on r4
    retire(4'd4);
    check("underflow_set",     32'(sb_if.underflow), 32'h1);
    check("underflow_pending", 32'(sb_if.pending),   32'h0);
    check("overflow_sticky",   32'(sb_if.overflow),  32'h1);

    // Fill every register, last one a load, then reset mid-cycle
    sb_if.forwardEn = 1'b1;
    sb_if.issueEn   = 1'b1;
    for (int r = 0; r < 16; r++) begin
      sb_if.issueDest    = 4'(r);
      sb_if.issueMemRead = (r == 15);
      tick();
    end
    sb_if.issueEn      = 1'b0;
    sb_if.issueMemRead = 1'b0;
    sb_if.freeze       = 1'b1;
    sb_if.src1         = 4'd15;
    #1;
    check("full_pending", 32'(sb_if.pending), 32'hFFFF);
    check("full_ld_hazard", 32'(sb_if.hazard), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_pending",   32'(sb_if.pending),   32'h0);
    check("async_overflow",  32'(sb_if.overflow),  32'h0);
    check("async_underflow", 32'(sb_if.underflow), 32'h0);
    check("async_hazard",    32'(sb_if.hazard),    32'h0);
    sb_if.forwardEn = 1'b0;
    sb_if.src2      = 4'd1;
    sb_if.twoSrc    = 1'b1;
    #1;
    check("async_hazard_nofwd", 32'(sb_if.hazard), 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_pending", 32'(sb_if.pending), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
